modulo_counter: RTL and testbench

MODULO_COUNTER -- requirements
Module: modulo_counter

---
 rtl/modulo_counter_if.sv | 28 ++
 rtl/modulo_counter.sv | 65 ++++++
 tb/tb_modulo_counter.sv | 118 +++++++++++
 3 files changed

// File: rtl/modulo_counter_if.sv
// modulo_counter_if: control/status bundle for modulo_counter (compare port under MODULO_COUNTER_CMP_EN)
interface modulo_counter_if #(parameter int WIDTH = 8);
    logic             clr;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             oneshot;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
`ifdef MODULO_COUNTER_CMP_EN
    logic [WIDTH-1:0] cmp_val;
    logic             match;
    modport master (output clr, en, up, load, load_val, start, stop, oneshot, cmp_val,
                    input count, tc, busy, done, match);
    modport slave  (input clr, en, up, load, load_val, start, stop, oneshot, cmp_val,
                    output count, tc, busy, done, match);
`else
    modport master (output clr, en, up, load, load_val, start, stop, oneshot,
                    input count, tc, busy, done);
    modport slave  (input clr, en, up, load, load_val, start, stop, oneshot,
                    output count, tc, busy, done);
`endif
endinterface

// File: rtl/modulo_counter.sv
// modulo_counter: up/down modulo counter with IDLE/RUN/DONE control, oneshot mode and optional compare (MODULO_COUNTER_CMP_EN)
module modulo_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input logic            clk,
    input logic            reset,
    modulo_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    state_t           state;
    logic             mode;
    logic [WIDTH-1:0] cnt;
    logic             tc_r;
    logic             step;
    logic             wrap;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] load_sat;
    // step qualification, terminal detection and explicit modulus wrap
    always_comb begin
        step     = (state == RUN) && !bus.stop && bus.en && !bus.load;
        wrap     = bus.up ? (cnt == MAX) : (cnt == '0);
        nxt      = bus.up ? (wrap ? '0 : cnt + 1'b1) : (wrap ? MAX : cnt - 1'b1);
        load_sat = (bus.load_val > MAX) ? MAX : bus.load_val;
    end
    // count, terminal pulse, mode latch and control state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt   <= '0;
            tc_r  <= 1'b0;
            state <= IDLE;
            mode  <= 1'b0;
        end else if (bus.clr) begin
            cnt   <= '0;
            tc_r  <= 1'b0;
            state <= IDLE;
            mode  <= 1'b0;
        end else begin
            tc_r <= step && wrap;
            if (bus.load) cnt <= load_sat;
            else if (step && !(wrap && mode)) cnt <= nxt;
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state <= RUN;
                    mode  <= bus.oneshot;
                end
                RUN: if (bus.stop) state <= IDLE;
                     else if (step && wrap && mode) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    assign bus.count = cnt;
    assign bus.tc    = tc_r;
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
`ifdef MODULO_COUNTER_CMP_EN
    logic match_r;
    // registered equality of the current count against cmp_val
    always_ff @(posedge clk or posedge reset)
        if (reset) match_r <= 1'b0;
        else match_r <= (cnt == bus.cmp_val);
    assign bus.match = match_r;
`endif
endmodule

// File: tb/tb_modulo_counter.sv
// tb_modulo_counter: directed self-checking bench for modulo_counter (WIDTH=8, MODULUS=10)
module tb_modulo_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    modulo_counter_if #(.WIDTH(8)) bus();
    modulo_counter #(.WIDTH(8), .MODULUS(10)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_st(input string tag, input int c, input bit t, input bit b, input bit d);
        chk({tag, ".count"}, 32'(bus.count), c);
        chk({tag, ".tc"}, 32'(bus.tc), 32'(t));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
    endtask
    initial begin
        bus.clr = 0; bus.en = 0; bus.up = 1; bus.load = 0; bus.load_val = 0;
        bus.start = 0; bus.stop = 0; bus.oneshot = 0;
`ifdef MODULO_COUNTER_CMP_EN
        bus.cmp_val = 8'd7;
`endif
        tick(); tick();
        chk_st("reset", 0, 0, 0, 0);
        reset = 0;
        tick();
        chk_st("post_reset_idle", 0, 0, 0, 0);
        // free-running up count across the 9->0 wrap
        bus.oneshot = 0; bus.up = 1; bus.en = 1; bus.start = 1;
        tick();
        bus.start = 0;
        chk_st("free_up_c0", 0, 0, 1, 0);
        for (int i = 1; i < 12; i++) begin
            tick();
            chk_st($sformatf("free_up_c%0d", i), i % 10, i == 10, 1, 0);
        end
        // asynchronous reset at count 5
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset.count", 32'(bus.count), 5);
        #2 reset = 1;
        #1 chk_st("async_reset", 0, 0, 0, 0);
        #1 reset = 0;
        tick(); tick();
        chk_st("no_step_after_reset", 0, 0, 0, 0);
        // oneshot down from a loaded 3
        bus.oneshot = 1; bus.up = 0; bus.load = 1; bus.load_val = 8'd3; bus.start = 1;
        tick();
        bus.load = 0; bus.start = 0;
        chk_st("oneshot_c3", 3, 0, 1, 0);
        tick(); chk_st("oneshot_c2", 2, 0, 1, 0);
        tick(); chk_st("oneshot_c1", 1, 0, 1, 0);
        tick(); chk_st("oneshot_c0", 0, 0, 1, 0);
        tick(); chk_st("oneshot_term", 0, 1, 0, 1);
        tick(); chk_st("oneshot_hold", 0, 0, 0, 1);
        // load saturation and load+clr priority
        bus.load = 1; bus.load_val = 8'd200;
        tick(); chk_st("load_sat", 9, 0, 0, 1);
        bus.load_val = 8'd5;
        tick(); chk_st("load_5", 5, 0, 0, 1);
        bus.clr = 1; bus.load_val = 8'd7;
        tick(); chk_st("clr_over_load", 0, 0, 0, 0);
        bus.clr = 0;
        // enable toggling, direction flip, stop
        bus.load_val = 8'd4; bus.start = 1; bus.oneshot = 0; bus.up = 1; bus.en = 1;
        tick(); chk_st("load4_start", 4, 0, 1, 0);
        bus.load = 0; bus.start = 0;
        tick(); chk_st("en1_up", 5, 0, 1, 0);
        bus.en = 0;
        tick(); chk_st("en0", 5, 0, 1, 0);
        bus.en = 1; bus.up = 0;
        tick(); chk_st("en1_down", 4, 0, 1, 0);
        bus.stop = 1;
        tick(); chk_st("stop", 4, 0, 0, 0);
        bus.stop = 0;
        tick(); chk_st("idle_hold", 4, 0, 0, 0);
        // free down wrap, then load coinciding with a terminal step
        bus.load = 1; bus.load_val = 8'd0; bus.start = 1;
        tick(); chk_st("load0_start", 0, 0, 1, 0);
        bus.load = 0; bus.start = 0;
        tick(); chk_st("down_wrap", 9, 1, 1, 0);
        bus.up = 1; bus.load = 1; bus.load_val = 8'd2;
        tick(); chk_st("load_suppress_tc", 2, 0, 1, 0);
        bus.load = 0;
        tick(); chk_st("after_load_step", 3, 0, 1, 0);
`ifdef MODULO_COUNTER_CMP_EN
        // compare match one cycle after count == 7
        begin
            int exp_c;
            int prev_c;
            bus.clr = 1;
            tick();
            bus.clr = 0; bus.start = 1; bus.oneshot = 0; bus.up = 1; bus.en = 1;
            tick();
            bus.start = 0;
            exp_c = 0;
            for (int i = 0; i < 22; i++) begin
                prev_c = exp_c;
                exp_c = (exp_c + 1) % 10;
                tick();
                chk($sformatf("cmp_count%0d", i), 32'(bus.count), exp_c);
                chk($sformatf("cmp_match%0d", i), 32'(bus.match), 32'(prev_c == 7));
            end
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
